// File: rtl/mips32_program_loader.sv
// -----------------------------------------------------------------------------
// mips32_program_loader
//
// Loads a program into an internal instruction store, then feeds it to a
// single-cycle MIPS32 core. The program arrives as 32-bit words over a
// valid/ready stream. When the last word has been written, the loader lets the
// core run. It serves instructions combinationally for the core's PC, with no
// fetch latency. Execution stops when the PC reaches HALT_PC or becomes
// misaligned.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   defined   -> checksum is the wrapping sum of words accepted since the
//                last accepted load_start
//   undefined -> checksum is tied to zero and no adder is built
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high
//   load_start       one-cycle request to start a load (IDLE/HALT only)
//   load_len         number of words to load, clipped to DEPTH_WORDS
//   load_valid       load_data carries a word
//   load_data        program word
//   load_ready       loader accepts a word this cycle (registered)
//   pc_in            processor PC (byte address)
//   instruction_out  instruction at pc_in (RUN/HALT), else zero
//   cpu_run          processor may advance its PC
//   done             PC reached HALT_PC
//   fault            misaligned PC seen while running
//   loaded_words     number of valid words in the store
//   checksum         see LOADER_CHECKSUM_EN above
// -----------------------------------------------------------------------------
module mips32_program_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] HALT_PC     = 32'h00000008
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  input  logic [31:0]       pc_in,
  output logic [31:0]       instruction_out,
  output logic              cpu_run,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W:0]   loaded_words,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH_WORDS);

  state_t              state, state_next;
  logic [31:0]         store [DEPTH_WORDS];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     len_q;
  logic                start_ok;
  logic                beat;
  logic                last_beat;
  logic                pc_misaligned;
  logic                pc_at_halt;
  logic                pc_in_range;
  logic [ADDR_W-1:0]   rd_idx;

  // Requested lengths above the store size are clipped silently.
  function automatic logic [ADDR_W:0] clip_len(input logic [ADDR_W:0] len);
    return (len > DEPTH_LEN) ? DEPTH_LEN : len;
  endfunction

  // A load request only counts in IDLE or HALT and with a non-zero length.
  assign start_ok  = load_start && (load_len != '0) &&
                     ((state == IDLE) || (state == HALT));
  // load_ready is only ever high in LOAD, so it qualifies the beat on its own.
  assign beat      = load_valid && load_ready;
  assign last_beat = beat && ({1'b0, wr_ptr} == (len_q - (ADDR_W+1)'(1)));

  assign pc_misaligned = (pc_in[1:0] != 2'b00);
  assign pc_at_halt    = (pc_in == HALT_PC);
  assign rd_idx        = pc_in[ADDR_W+1:2];
  assign pc_in_range   = (pc_in[31:ADDR_W+2] == '0) &&
                         ({1'b0, rd_idx} < loaded_words);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: if (last_beat) state_next = RUN;
      RUN:  if (pc_misaligned || pc_at_halt) state_next = HALT;
      HALT: if (start_ok) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      load_ready   <= 1'b0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      loaded_words <= '0;
      wr_ptr       <= '0;
      len_q        <= '0;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == LOAD);
      cpu_run    <= (state_next == RUN);
      if (start_ok) begin
        wr_ptr       <= '0;
        loaded_words <= '0;
        len_q        <= clip_len(load_len);
        done         <= 1'b0;
        fault        <= 1'b0;
      end else if (beat) begin
        wr_ptr       <= wr_ptr + ADDR_W'(1);
        loaded_words <= loaded_words + (ADDR_W+1)'(1);
      end
      // A misaligned PC wins over a PC that also matches HALT_PC.
      if (state == RUN) begin
        if (pc_misaligned)   fault <= 1'b1;
        else if (pc_at_halt) done  <= 1'b1;
      end
    end
  end

  // Store contents survive reset; a reset cycle still blocks the write.
  always_ff @(posedge clock) begin
    if (beat && !reset) store[wr_ptr] <= load_data;
  end

  always_comb begin
    instruction_out = 32'h00000000;
    if (((state == RUN) || (state == HALT)) && pc_in_range)
      instruction_out = store[rd_idx];
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (beat)     checksum <= checksum + load_data;
  end
`else
  assign checksum = 32'h00000000;
`endif

endmodule

// File: tb/tb_mips32_program_loader.sv
module tb_mips32_program_loader;

  localparam int ADDR_W = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              load_valid = 1'b0;
  logic [31:0]       load_data = '0;
  logic              load_ready;
  logic [31:0]       pc_in = '0;
  logic [31:0]       instruction_out;
  logic              cpu_run;
  logic              done;
  logic              fault;
  logic [ADDR_W:0]   loaded_words;
  logic [31:0]       checksum;

  int pass_cnt = 0;
  int total_cnt = 0;

  mips32_program_loader #(
    .DEPTH_WORDS(64),
    .ADDR_W(ADDR_W),
    .HALT_PC(32'h00000008)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load_start(load_start),
    .load_len(load_len),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .pc_in(pc_in),
    .instruction_out(instruction_out),
    .cpu_run(cpu_run),
    .done(done),
    .fault(fault),
    .loaded_words(loaded_words),
    .checksum(checksum)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic feed_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    pc_in      = 32'h0;
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_instr;
  } rd_vec_t;

  localparam logic [31:0] W0 = 32'h02118020;
  localparam logic [31:0] W1 = 32'h02329820;
  localparam logic [31:0] W2 = 32'hAE130004;

  rd_vec_t rd_tab [4];
  logic [31:0] exp_sum;
  int beats;

  initial begin
    rd_tab[0] = '{pc: 32'h00000000, exp_instr: W0};
    rd_tab[1] = '{pc: 32'h00000004, exp_instr: W1};
    rd_tab[2] = '{pc: 32'h0000000C, exp_instr: 32'h0};  // beyond loaded_words
    rd_tab[3] = '{pc: 32'h00000100, exp_instr: 32'h0};  // upper PC bits set

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_loaded_words", 32'(loaded_words), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("idle_instr", instruction_out, 32'd0);

    // Load three words back to back
    start_load(3);
    check("l1_ready_c1", 32'(load_ready), 32'd1);
    feed_word(W0);
    check("l1_ready_c2", 32'(load_ready), 32'd1);
    check("l1_words_1", 32'(loaded_words), 32'd1);
    feed_word(W1);
    check("l1_ready_c3", 32'(load_ready), 32'd1);
    feed_word(W2);
    load_valid = 1'b0;
    check("l1_cpu_run", 32'(cpu_run), 32'd1);
    check("l1_ready_off", 32'(load_ready), 32'd0);
    check("l1_loaded_words", 32'(loaded_words), 32'd3);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'hB2571844;
`else
    exp_sum = 32'h0;
`endif
    check("l1_checksum", checksum, exp_sum);

    // Table-driven reads while running
    for (int i = 0; i < 4; i++) begin
      pc_in = rd_tab[i].pc;
      #1;
      check($sformatf("run_rd%0d_instr", i), instruction_out, rd_tab[i].exp_instr);
      tick();
      check($sformatf("run_rd%0d_cpu_run", i), 32'(cpu_run), 32'd1);
    end

    // Reach HALT_PC
    pc_in = 32'h8;
    #1;
    check("halt_pc_instr", instruction_out, W2);
    tick();
    check("halt_done", 32'(done), 32'd1);
    check("halt_cpu_run", 32'(cpu_run), 32'd0);
    check("halt_fault", 32'(fault), 32'd0);
    pc_in = 32'h4;
    #1;
    check("halt_inspect", instruction_out, W1);

    // Reload with gaps in load_valid: 1,0,0,1,1
    start_load(3);
    check("l2_done_clr", 32'(done), 32'd0);
    check("l2_ready", 32'(load_ready), 32'd1);
    feed_word(32'h11111111);
    load_valid = 1'b0; load_data = 32'hDEADBEEF; tick();
    load_valid = 1'b0; load_data = 32'hBADBAD00; tick();
    check("l2_gap_words", 32'(loaded_words), 32'd1);
    check("l2_gap_ready", 32'(load_ready), 32'd1);
    feed_word(32'h22222222);
    feed_word(32'h33333333);
    load_valid = 1'b0;
    check("l2_cpu_run", 32'(cpu_run), 32'd1);
    check("l2_loaded_words", 32'(loaded_words), 32'd3);
    pc_in = 32'h0; #1; check("l2_rd0", instruction_out, 32'h11111111);
    pc_in = 32'h4; #1; check("l2_rd1", instruction_out, 32'h22222222);
    pc_in = 32'hC; #1; check("l2_rd3_nop", instruction_out, 32'h0);

    // Misaligned PC faults
    pc_in = 32'h6;
    tick();
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_done", 32'(done), 32'd0);
    check("flt_cpu_run", 32'(cpu_run), 32'd0);

    // load_start len=1 clears the fault and loads again
    start_load(1);
    check("l3_fault_clr", 32'(fault), 32'd0);
    check("l3_ready", 32'(load_ready), 32'd1);
    check("l3_words_clr", 32'(loaded_words), 32'd0);
    feed_word(32'hCAFE0001);
    load_data = 32'hFFFF0002;   // keep valid high past the last beat
    check("l3_cpu_run", 32'(cpu_run), 32'd1);
    tick();
    load_valid = 1'b0;
    check("l3_no_extra", 32'(loaded_words), 32'd1);
    pc_in = 32'h0; #1; check("l3_rd0", instruction_out, 32'hCAFE0001);
    pc_in = 32'h4; #1; check("l3_rd1_nop", instruction_out, 32'h0);

    // load_start ignored in RUN
    load_start = 1'b1; load_len = 2; tick(); load_start = 1'b0;
    check("run_ign_start", 32'(cpu_run), 32'd1);
    check("run_ign_ready", 32'(load_ready), 32'd0);

    // Halt, then reset in the middle of a 4-word load
    pc_in = 32'h8; tick();
    check("h2_done", 32'(done), 32'd1);
    start_load(4);
    feed_word(32'hE0E0E0E0);
    feed_word(32'hE1E1E1E1);
    check("mid_words", 32'(loaded_words), 32'd2);
    reset = 1'b1; load_data = 32'h99999999; tick();
    reset = 1'b0; load_valid = 1'b0;
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    check("mid_rst_words", 32'(loaded_words), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_run", 32'(cpu_run), 32'd0);
    check("mid_rst_instr", instruction_out, 32'h0);

    // Zero-length request is ignored
    start_load(0);
    check("len0_ready", 32'(load_ready), 32'd0);

    start_load(4);
    for (int i = 0; i < 4; i++) feed_word(32'hF0000000 + 32'(i));
    load_valid = 1'b0;
    check("l4_cpu_run", 32'(cpu_run), 32'd1);
    check("l4_words", 32'(loaded_words), 32'd4);
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'(i * 4);
      #1;
      check($sformatf("l4_rd%0d", i), instruction_out, 32'hF0000000 + 32'(i));
    end

    // Oversized length clips to 64
    pc_in = 32'h8; tick();
    start_load(100);
    beats = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 200 && !cpu_run; i++) begin
      load_data = 32'(beats + 1);
      if (load_ready) beats++;
      tick();
    end
    load_valid = 1'b0;
    check("clip_cpu_run", 32'(cpu_run), 32'd1);
    check("clip_beats", 32'(beats), 32'd64);
    check("clip_words", 32'(loaded_words), 32'd64);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'd2080;
`else
    exp_sum = 32'd0;
`endif
    check("clip_checksum", checksum, exp_sum);
    pc_in = 32'h0;  #1; check("clip_rd0", instruction_out, 32'd1);
    pc_in = 32'hFC; #1; check("clip_rd63", instruction_out, 32'd64);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
